mux_rr_arbiter: RTL and testbench

Two-channel round-robin arbiter with packet locking. It sits directly upstream of the 2:1 mux datapath and generates that mux's select. It accepts two valid/ready input streams, grants one channel at a time, and keeps a granted channel locked until its packet ends. The selected beat goes into a single registered output slot together with the source channel ID.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/mux2_bus.sv | 18 +
 rtl/mux_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-channel round-robin arbiter.
// Contents:
//   state_t  - arbiter lock state (IDLE / LOCK0 / LOCK1; 2'd3 is illegal
//              and is steered back to IDLE by the arbiter)
//   CH0/CH1  - channel IDs, also used as mux select values
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/mux2_bus.sv
// DATA_W-wide 2:1 multiplexer carrying the granted beat toward the
// arbiter's output slot.
// Ports:
//   i0, i1 - candidate beats from channel 0 / channel 1
//   s      - select (0 = i0, 1 = i1)
//   out    - selected beat
module mux2_bus #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  input  logic              s,
  output logic [DATA_W-1:0] out
);

  assign out = s ? i1 : i0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-channel round-robin arbiter with packet locking. It drives the select
// of the 2:1 data mux and captures the granted beat into one registered
// output slot tagged with its source channel.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   in0_* / in1_*                   - valid/ready input streams (data, last)
//   s                               - combinational mux select (current grant)
//   out_data/out_valid/out_last/out_src - registered output slot
//   out_ready                       - downstream accepts the held beat
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              s,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);

  state_t            state_r;
  logic              ptr_r;          // channel that won most recently at packet end
  logic              grant_valid_s;  // a granted channel has a beat present
  logic              grant_ch_s;
  logic              load_en_s;
  logic              accept_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;

  // The slot can take a new beat when empty or when it drains this cycle.
  assign load_en_s = !out_valid | out_ready;

  // Grant selection: free arbitration in IDLE, fixed channel while locked.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_ch_s    = ptr_r;
    case (state_r)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          grant_valid_s = 1'b1;
          grant_ch_s    = ~ptr_r;
        end else if (in0_valid) begin
          grant_valid_s = 1'b1;
          grant_ch_s    = CH0;
        end else if (in1_valid) begin
          grant_valid_s = 1'b1;
          grant_ch_s    = CH1;
        end else begin
          grant_valid_s = 1'b0;
          grant_ch_s    = ptr_r;
        end
      end
      LOCK0: begin
        grant_valid_s = in0_valid;
        grant_ch_s    = CH0;
      end
      LOCK1: begin
        grant_valid_s = in1_valid;
        grant_ch_s    = CH1;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_ch_s    = ptr_r;
      end
    endcase
  end

  assign s = grant_ch_s;

  // Readies are held low during reset so no beat is consumed and then lost.
  assign in0_ready = !rst & load_en_s & grant_valid_s & (grant_ch_s == CH0);
  assign in1_ready = !rst & load_en_s & grant_valid_s & (grant_ch_s == CH1);
  assign accept_s  = in0_ready | in1_ready;

  assign sel_last_s = s ? in1_last : in0_last;

  mux2_bus #(
    .DATA_W (DATA_W)
  ) u_mux (
    .i0  (in0_data),
    .i1  (in1_data),
    .s   (s),
    .out (sel_data_s)
  );

  // Output slot: load the granted beat on accept, empty it on an idle drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (load_en_s) begin
      out_valid <= accept_s;
      if (accept_s) begin
        out_data <= sel_data_s;
        out_last <= sel_last_s;
        out_src  <= grant_ch_s;
      end
    end
  end

  // Lock FSM and priority pointer; the pointer moves only at packet end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= CH1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (sel_last_s) begin
              ptr_r <= grant_ch_s;
            end else begin
              state_r <= (grant_ch_s == CH1) ? LOCK1 : LOCK0;
            end
          end
        end
        LOCK0, LOCK1: begin
          if (accept_s && sel_last_s) begin
            state_r <= IDLE;
            ptr_r   <= grant_ch_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter. A behavioural reference model
// predicts grants and readies each cycle and pushes accepted beats into a
// scoreboard queue that is compared against the output slot.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
  logic       in0_valid = 1'b0, in1_valid = 1'b0;
  logic       in0_last = 1'b0, in1_last = 1'b0;
  logic       in0_ready, in1_ready, s;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_src;
  logic       out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // source queues: {last, data}
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  // scoreboard: {src, last, data}
  logic [9:0] sb[$];

  // reference model state
  logic [1:0] m_state = 2'd0;
  logic       m_ptr   = 1'b1;
  logic       m_ov    = 1'b0;
  bit         rand_ready = 1'b0;

  mux_rr_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .s         (s),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_beat(input int ch, input logic [7:0] d, input logic l);
    if (ch == 0) src0.push_back({l, d});
    else         src1.push_back({l, d});
  endtask

  // One clock of stimulus + checking, all done around the falling edge.
  task automatic step();
    logic       gv, gch, load, r0, r1, acc, lst;
    logic [8:0] beat;
    @(negedge clk);
    in0_valid = (src0.size() > 0);
    in1_valid = (src1.size() > 0);
    {in0_last, in0_data} = in0_valid ? src0[0] : 9'h0EE;
    {in1_last, in1_data} = in1_valid ? src1[0] : 9'h0DD;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    // output slot
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'd0, 32'd1);
      end else begin
        check_eq("out_data", {24'd0, out_data}, {24'd0, sb[0][7:0]});
        check_eq("out_last", {31'd0, out_last}, {31'd0, sb[0][8]});
        check_eq("out_src",  {31'd0, out_src},  {31'd0, sb[0][9]});
        if (out_ready) void'(sb.pop_front());
      end
    end
    // reference grant
    gv = 1'b0; gch = m_ptr;
    case (m_state)
      2'd0: begin
        if (in0_valid && in1_valid) begin gv = 1'b1; gch = ~m_ptr; end
        else if (in0_valid) begin gv = 1'b1; gch = 1'b0; end
        else if (in1_valid) begin gv = 1'b1; gch = 1'b1; end
      end
      2'd1: begin gv = in0_valid; gch = 1'b0; end
      2'd2: begin gv = in1_valid; gch = 1'b1; end
      default: begin gv = 1'b0; end
    endcase
    load = !m_ov | out_ready;
    r0 = load & gv & (gch == 1'b0);
    r1 = load & gv & (gch == 1'b1);
    acc = r0 | r1;
    check_eq("in0_ready", {31'd0, in0_ready}, {31'd0, r0});
    check_eq("in1_ready", {31'd0, in1_ready}, {31'd0, r1});
    check_eq("s", {31'd0, s}, {31'd0, gch});
    if (acc) begin
      beat = gch ? src1.pop_front() : src0.pop_front();
      lst  = beat[8];
      sb.push_back({gch, beat});
      case (m_state)
        2'd0: begin
          if (lst) m_ptr = gch;
          else     m_state = gch ? 2'd2 : 2'd1;
        end
        default: begin
          if (lst) begin m_state = 2'd0; m_ptr = gch; end
        end
      endcase
    end
    if (load) m_ov = acc;
  endtask

  // Reset pulse with traffic present: slot empties, readies stay low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'h99; in1_data = 8'h98;
    out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_src",   {31'd0, out_src},   32'd0);
    check_eq("rst_out_data",  {24'd0, out_data},  32'd0);
    check_eq("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    check_eq("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    m_state = 2'd0; m_ptr = 1'b1; m_ov = 1'b0;
    sb.delete(); src0.delete(); src1.delete();
  endtask

  initial begin
    do_reset();
    // first tie after reset goes to ch0
    push_beat(0, 8'hC0, 1'b1); push_beat(1, 8'hC1, 1'b1);
    repeat (4) step();

    // alternation of single-beat packets
    for (int i = 0; i < 4; i++) begin
      push_beat(0, 8'hA0 + 8'(i), 1'b1);
      push_beat(1, 8'hB0 + 8'(i), 1'b1);
    end
    repeat (10) step();

    // packet lock: ch0 3-beat packet while ch1 waits
    push_beat(0, 8'h11, 1'b0); push_beat(0, 8'h12, 1'b0); push_beat(0, 8'h13, 1'b1);
    push_beat(1, 8'h55, 1'b1);
    repeat (7) step();

    // backpressure: hold 0x22 for 4 cycles
    push_beat(0, 8'h22, 1'b1); push_beat(0, 8'h23, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_out_data", {24'd0, out_data}, 32'h22);
      check_eq("bp_in0_ready", {31'd0, in0_ready}, 32'd0);
      check_eq("bp_in1_ready", {31'd0, in1_ready}, 32'd0);
    end
    repeat (4) step();

    // single channel back-to-back, then tie goes to ch0
    for (int i = 0; i < 4; i++) push_beat(1, 8'h7E, 1'b1);
    repeat (6) step();
    push_beat(0, 8'h30, 1'b1); push_beat(1, 8'h31, 1'b1);
    repeat (4) step();

    // reset while ch1 holds the lock
    push_beat(1, 8'h40, 1'b0); push_beat(1, 8'h41, 1'b0); push_beat(1, 8'h42, 1'b1);
    repeat (2) step();
    do_reset();
    push_beat(0, 8'h60, 1'b1); push_beat(1, 8'h61, 1'b1);
    repeat (4) step();

    // random packets with random backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 24; p++) begin
      int len;
      int ch;
      len = $urandom_range(1, 3);
      ch  = $urandom_range(0, 1);
      for (int b = 0; b < len; b++)
        push_beat(ch, 8'($urandom_range(0, 255)), (b == len - 1) ? 1'b1 : 1'b0);
    end
    repeat (200) step();
    rand_ready = 1'b0;
    repeat (60) step();

    check_eq("drain_src0", src0.size(), 32'd0);
    check_eq("drain_src1", src1.size(), 32'd0);
    check_eq("drain_sb", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
